cpu_trap_ctrl: RTL and testbench

Trap/halt controller sitting directly downstream of `cpu3`'s `halt` and `exception` outputs. It turns those raw level signals into pipeline control: a fixed-length flush, a stall held until firmware/bench acknowledgement, captured exception PC and cause, and a sticky halted state. `cpu3`'s fetch/decode stages consume `stall`, `flush` and `redirect` from this block.

---
 rtl/cpu_ctrl_pkg.sv | 20 ++
 rtl/cpu_trap_ctrl_sat_counter.sv | 29 ++
 rtl/cpu_trap_ctrl.sv | 151 +++++++++++++++
 tb/tb_cpu_trap_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Shared types and default constants for the cpu3 trap/halt controller.
//   trap_state_t      : controller FSM state encoding
//   PC_W_DEFAULT      : default PC / vector width
//   CAUSE_W_DEFAULT   : default exception cause width
//   EXC_VECTOR_DEFAULT: default exception handler address
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    EXC_WAIT = 2'd2,
    HALTED   = 2'd3
  } trap_state_t;

  localparam int                PC_W_DEFAULT       = 32;
  localparam int                CAUSE_W_DEFAULT    = 4;
  localparam logic [31:0]       EXC_VECTOR_DEFAULT = 32'h0000_0100;

endpackage

// File: rtl/cpu_trap_ctrl_sat_counter.sv
// sat_counter
// Synchronous up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk    in   clock, rising edge
//   rst_   in   asynchronous active-low reset, clears count
//   clear  in   synchronous clear (wins over inc)
//   inc    in   increment by one when not saturated
//   count  out  WIDTH-bit count value
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cpu_trap_ctrl.sv
// cpu_trap_ctrl
// Turns cpu3's raw halt/exception levels into pipeline control: a fixed-length
// flush with a redirect pulse on its last cycle, a stall held until exc_ack,
// captured epc/cause, and a sticky HALTED state left only via resume.
//
// Optional feature macro: CPU_TRAP_EXC_COUNT_EN
//   defined     -> exc_count is a saturating count of accepted exceptions
//   not defined -> exc_count tied to zero, no counter logic
//
// Ports:
//   clk          in   clock, rising edge
//   rst_         in   asynchronous active-low reset
//   halt         in   level from cpu3
//   exception    in   level from cpu3
//   pc           in   PC of the instruction raising the exception
//   exc_cause    in   cause code, valid with exception
//   exc_ack      in   pulse: handler accepted, resume
//   resume       in   pulse: leave HALTED
//   stall        out  freeze fetch/decode
//   flush        out  kill in-flight instructions
//   redirect     out  pulse on last flush cycle: load redirect_pc
//   redirect_pc  out  constant EXC_VECTOR
//   epc          out  captured exception PC
//   cause        out  captured cause
//   exc_pending  out  exception awaiting exc_ack
//   halted       out  controller in HALTED
//   exc_lost     out  sticky: exception arrived while one was in service
//   exc_count    out  saturating accepted-exception count (see macro above)
//
// state    | meaning
// RUN      | normal execution, watching halt/exception
// FLUSH    | flush+stall for FLUSH_CYCLES cycles, redirect on the last one
// EXC_WAIT | stall until the handler acknowledges with exc_ack
// HALTED   | stall until resume; halt/exception ignored
module cpu_trap_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int                PC_W         = PC_W_DEFAULT,
  parameter int                CAUSE_W      = CAUSE_W_DEFAULT,
  parameter int                FLUSH_CYCLES = 3,
  parameter logic [PC_W-1:0]   EXC_VECTOR   = PC_W'(EXC_VECTOR_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               halt,
  input  logic               exception,
  input  logic [PC_W-1:0]    pc,
  input  logic [CAUSE_W-1:0] exc_cause,
  input  logic               exc_ack,
  input  logic               resume,
  output logic               stall,
  output logic               flush,
  output logic               redirect,
  output logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    epc,
  output logic [CAUSE_W-1:0] cause,
  output logic               exc_pending,
  output logic               halted,
  output logic               exc_lost,
  output logic [15:0]        exc_count
);

  // Counter loads N-1 so that values N-1..0 give exactly N flush cycles.
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  trap_state_t state, state_next;
  logic [3:0]  flush_cnt, flush_cnt_next;
  logic        capture;
  logic        lost_evt;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state     <= RUN;
      flush_cnt <= '0;
      epc       <= '0;
      cause     <= '0;
      exc_lost  <= 1'b0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
      if (capture) begin
        epc   <= pc;
        cause <= exc_cause;
      end
      if (lost_evt) begin
        exc_lost <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    capture        = 1'b0;
    lost_evt       = 1'b0;
    case (state)
      RUN: begin
        if (exception) begin
          capture        = 1'b1;
          flush_cnt_next = FLUSH_LOAD;
          state_next     = FLUSH;
        end else if (halt) begin
          state_next = HALTED;
        end
      end
      FLUSH: begin
        lost_evt = exception;
        if (flush_cnt == 4'd0) begin
          state_next = EXC_WAIT;
        end else begin
          flush_cnt_next = flush_cnt - 4'd1;
        end
      end
      EXC_WAIT: begin
        lost_evt = exception;
        if (exc_ack) begin
          state_next = RUN;
        end
      end
      HALTED: begin
        if (resume) begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // Moore outputs decoded from registered state only.
  assign stall       = (state != RUN);
  assign flush       = (state == FLUSH);
  assign redirect    = (state == FLUSH) && (flush_cnt == 4'd0);
  assign exc_pending = (state == EXC_WAIT);
  assign halted      = (state == HALTED);
  assign redirect_pc = EXC_VECTOR;

`ifdef CPU_TRAP_EXC_COUNT_EN
  sat_counter #(
    .WIDTH (16)
  ) u_exc_count (
    .clk   (clk),
    .rst_  (rst_),
    .clear (1'b0),
    .inc   (capture),
    .count (exc_count)
  );
`else
  assign exc_count = 16'h0000;
`endif

endmodule

// File: tb/tb_cpu_trap_ctrl.sv
module tb_cpu_trap_ctrl;

  logic        clk;
  logic        rst_;
  logic        halt;
  logic        exception;
  logic [31:0] pc;
  logic [3:0]  exc_cause;
  logic        exc_ack;
  logic        resume;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] epc;
  logic [3:0]  cause;
  logic        exc_pending;
  logic        halted;
  logic        exc_lost;
  logic [15:0] exc_count;

  int checks   = 0;
  int failures = 0;

  cpu_trap_ctrl dut (
    .clk         (clk),
    .rst_        (rst_),
    .halt        (halt),
    .exception   (exception),
    .pc          (pc),
    .exc_cause   (exc_cause),
    .exc_ack     (exc_ack),
    .resume      (resume),
    .stall       (stall),
    .flush       (flush),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .epc         (epc),
    .cause       (cause),
    .exc_pending (exc_pending),
    .halted      (halted),
    .exc_lost    (exc_lost),
    .exc_count   (exc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef CPU_TRAP_EXC_COUNT_EN
    return 32'(n);
`else
    return 32'(0 * n);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Control outputs in one go: stall, flush, redirect, exc_pending, halted.
  task automatic chk_ctl(input string tag, input logic s, input logic f,
                         input logic r, input logic p, input logic h);
    chk({tag, ".stall"},       32'(stall),       32'(s));
    chk({tag, ".flush"},       32'(flush),       32'(f));
    chk({tag, ".redirect"},    32'(redirect),    32'(r));
    chk({tag, ".exc_pending"}, 32'(exc_pending), 32'(p));
    chk({tag, ".halted"},      32'(halted),      32'(h));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_      = 1'b0;
    halt      = 1'b0;
    exception = 1'b0;
    pc        = 32'h0;
    exc_cause = 4'h0;
    exc_ack   = 1'b0;
    resume    = 1'b0;

    // Reset held three cycles.
    repeat (3) step();
    chk_ctl("in_reset", 0, 0, 0, 0, 0);
    rst_ = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step();
      chk_ctl("idle", 0, 0, 0, 0, 0);
    end
    chk("idle.epc",         epc,               32'h0);
    chk("idle.cause",       32'(cause),        32'h0);
    chk("idle.exc_lost",    32'(exc_lost),     32'h0);
    chk("idle.exc_count",   32'(exc_count),    exp_cnt(0));
    chk("idle.redirect_pc", redirect_pc,       32'h100);

    // Single exception: 3 flush cycles, redirect on the 3rd.
    exception = 1'b1; pc = 32'h40; exc_cause = 4'h5;
    step();
    exception = 1'b0; pc = 32'h0; exc_cause = 4'h0;
    chk_ctl("exc1.f1", 1, 1, 0, 0, 0);
    chk("exc1.epc",       epc,            32'h40);
    chk("exc1.cause",     32'(cause),     32'h5);
    chk("exc1.exc_count", 32'(exc_count), exp_cnt(1));
    step();
    chk_ctl("exc1.f2", 1, 1, 0, 0, 0);
    step();
    chk_ctl("exc1.f3", 1, 1, 1, 0, 0);
    chk("exc1.redirect_pc", redirect_pc, 32'h100);
    step();
    chk_ctl("exc1.wait", 1, 0, 0, 1, 0);
    step();
    chk_ctl("exc1.wait2", 1, 0, 0, 1, 0);

    // Second exception while waiting: lost, captured values untouched.
    exception = 1'b1; pc = 32'h80; exc_cause = 4'h9;
    step();
    exception = 1'b0; pc = 32'h0; exc_cause = 4'h0;
    chk("lost.exc_lost",  32'(exc_lost),  32'h1);
    chk("lost.epc",       epc,            32'h40);
    chk("lost.cause",     32'(cause),     32'h5);
    chk("lost.exc_count", 32'(exc_count), exp_cnt(1));
    chk_ctl("lost.wait", 1, 0, 0, 1, 0);

    exc_ack = 1'b1;
    step();
    exc_ack = 1'b0;
    chk_ctl("ack", 0, 0, 0, 0, 0);

    // exc_ack in RUN is ignored.
    exc_ack = 1'b1;
    step();
    exc_ack = 1'b0;
    chk_ctl("ack_in_run", 0, 0, 0, 0, 0);

    // halt and exception together: exception wins.
    halt = 1'b1; exception = 1'b1; pc = 32'hC0; exc_cause = 4'h3;
    step();
    halt = 1'b0; exception = 1'b0; pc = 32'h0; exc_cause = 4'h0;
    chk_ctl("both.f1", 1, 1, 0, 0, 0);
    chk("both.epc",       epc,            32'hC0);
    chk("both.cause",     32'(cause),     32'h3);
    chk("both.exc_count", 32'(exc_count), exp_cnt(2));
    step();
    chk_ctl("both.f2", 1, 1, 0, 0, 0);
    step();
    chk_ctl("both.f3", 1, 1, 1, 0, 0);
    step();
    chk_ctl("both.wait", 1, 0, 0, 1, 0);
    exc_ack = 1'b1;
    step();
    exc_ack = 1'b0;
    chk_ctl("both.ack", 0, 0, 0, 0, 0);

    // Halt, exception ignored while halted, resume.
    halt = 1'b1;
    step();
    halt = 1'b0;
    chk_ctl("halt", 1, 0, 0, 0, 1);
    exception = 1'b1; pc = 32'h200; exc_cause = 4'hA;
    step();
    exception = 1'b0; pc = 32'h0; exc_cause = 4'h0;
    chk_ctl("halt.exc", 1, 0, 0, 0, 1);
    chk("halt.epc",       epc,            32'hC0);
    chk("halt.exc_count", 32'(exc_count), exp_cnt(2));
    exc_ack = 1'b1;
    step();
    exc_ack = 1'b0;
    chk_ctl("halt.ack_ignored", 1, 0, 0, 0, 1);
    resume = 1'b1;
    step();
    resume = 1'b0;
    chk_ctl("resume", 0, 0, 0, 0, 0);
    step();
    chk_ctl("resume.stay", 0, 0, 0, 0, 0);

    // resume with halt still high: leaves for one cycle, then re-enters.
    halt = 1'b1;
    step();
    chk_ctl("halt2", 1, 0, 0, 0, 1);
    resume = 1'b1;
    step();
    resume = 1'b0;
    chk_ctl("halt2.resume", 0, 0, 0, 0, 0);
    step();
    chk_ctl("halt2.reenter", 1, 0, 0, 0, 1);
    halt = 1'b0;
    resume = 1'b1;
    step();
    resume = 1'b0;
    chk_ctl("halt2.exit", 0, 0, 0, 0, 0);

    // Reset asserted during the 2nd flush cycle aborts immediately.
    exception = 1'b1; pc = 32'h300; exc_cause = 4'h7;
    step();
    exception = 1'b0; pc = 32'h0; exc_cause = 4'h0;
    chk("rst.epc_before", epc, 32'h300);
    step();
    chk_ctl("rst.f2", 1, 1, 0, 0, 0);
    #2;
    rst_ = 1'b0;
    #1;
    chk_ctl("rst.async", 0, 0, 0, 0, 0);
    chk("rst.epc",       epc,            32'h0);
    chk("rst.cause",     32'(cause),     32'h0);
    chk("rst.exc_lost",  32'(exc_lost),  32'h0);
    chk("rst.exc_count", 32'(exc_count), 32'h0);
    step();
    rst_ = 1'b1;
    step();
    chk_ctl("rst.release", 0, 0, 0, 0, 0);
    step();
    chk_ctl("rst.run", 0, 0, 0, 0, 0);

    // Exception after reset behaves normally and counts from zero.
    exception = 1'b1; pc = 32'h44; exc_cause = 4'hE;
    step();
    exception = 1'b0; pc = 32'h0; exc_cause = 4'h0;
    chk_ctl("post.f1", 1, 1, 0, 0, 0);
    chk("post.epc",       epc,            32'h44);
    chk("post.cause",     32'(cause),     32'hE);
    chk("post.exc_count", 32'(exc_count), exp_cnt(1));
    chk("post.exc_lost",  32'(exc_lost),  32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
